// File: rtl/terrain_pkg.sv
// Shared constants and types for the terrain sweep scheduler: cube count,
// source/mode/id codes, checker flag bit positions and coordinate widths.
package terrain_pkg;

  localparam int NUM_CUBES = 50;
  localparam int CNT_W     = 6;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int FLG_W     = 4;

  localparam logic [1:0] SRC_PLY = 2'd0;
  localparam logic [1:0] SRC_SH  = 2'd1;
  localparam logic [1:0] SRC_EXP = 2'd2;

  localparam logic MODE_COLLIDE = 1'b0;
  localparam logic MODE_EXPLODE = 1'b1;

  localparam logic ID_SHELL  = 1'b0;
  localparam logic ID_PLAYER = 1'b1;

  // Bit positions inside the checker's {up,support,left,right} flag word
  localparam int FLG_RIGHT = 0;
  localparam int FLG_LEFT  = 1;
  localparam int FLG_SUP   = 2;
  localparam int FLG_UP    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_HOLD
  } sched_state_t;

endpackage

// File: rtl/sweep_rr_arbiter.sv
// Request arbiter for the terrain checker: explosion always wins, player and
// shell alternate when both ask. Grant vector is one-hot, indexed by source code.
module sweep_rr_arbiter
  import terrain_pkg::*;
(
  input  logic       en,
  input  logic       req_ply,
  input  logic       req_sh,
  input  logic       req_exp,
  input  logic       rr_last,
  output logic [2:0] gnt,
  output logic [1:0] win_src,
  output logic       win_valid
);

  // rr_last = 1 means the player was served most recently between player/shell
  always_comb begin
    win_valid = en & (req_exp | req_ply | req_sh);
    win_src   = SRC_PLY;
    if (req_exp) begin
      win_src = SRC_EXP;
    end else if (req_ply && req_sh) begin
      win_src = rr_last ? SRC_SH : SRC_PLY;
    end else if (req_sh) begin
      win_src = SRC_SH;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
    assign gnt[gi] = win_valid && (win_src == 2'(gi));
  end

endmodule

// File: rtl/terrain_sweep_scheduler.sv
// Time-shares the cube terrain checker between player collision, shell collision
// and shell explosion; one full cube sweep per grant, flags ORed into one result.
// Define TERRAIN_SCHED_STATS_EN for the sweep counter and the optional HOLD timeout.
module terrain_sweep_scheduler
  import terrain_pkg::*;
#(
  parameter int NUM_CUBES = terrain_pkg::NUM_CUBES,
  parameter int FLAG_LAT  = 1,
  parameter int RESULT_TO = 0
) (
  input  logic             clock_1M,
  input  logic             rst_n,
  input  logic             ply_req,
  input  logic [X_W-1:0]   ply_x,
  input  logic [Y_W-1:0]   ply_y,
  output logic             ply_gnt,
  input  logic             sh_req,
  input  logic [X_W-1:0]   sh_x,
  input  logic [Y_W-1:0]   sh_y,
  output logic             sh_gnt,
  input  logic             exp_req,
  output logic             exp_gnt,
  output logic             eng_mode,
  output logic             eng_id,
  output logic [X_W-1:0]   eng_x,
  output logic [Y_W-1:0]   eng_y,
  input  logic [FLG_W-1:0] eng_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_src,
  output logic [FLG_W-1:0] res_flags,
  output logic [15:0]      sweep_cnt
);

`ifdef TERRAIN_SCHED_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  localparam int DRAIN_CYC = (FLAG_LAT < 1) ? 1 : FLAG_LAT;
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(NUM_CUBES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] ACC_FIRST  = CNT_W'(FLAG_LAT);

  sched_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rr_last_reg, rr_last_next;
  logic             mode_reg, mode_next;
  logic             id_reg, id_next;
  logic [X_W-1:0]   x_reg, x_next;
  logic [Y_W-1:0]   y_reg, y_next;
  logic [1:0]       src_reg, src_next;
  logic [FLG_W-1:0] acc_reg, acc_next;
  logic [15:0]      sweep_cnt_reg, sweep_cnt_next;
  logic [15:0]      hold_cnt_reg, hold_cnt_next;

  logic             arb_en;
  logic [2:0]       gnt;
  logic [1:0]       win_src;
  logic             win_valid;
  logic             hold_timeout;

  // Grants only exist while idle and out of reset
  assign arb_en = (state_reg == ST_IDLE) && rst_n;

  sweep_rr_arbiter u_arb (
    .en        (arb_en),
    .req_ply   (ply_req),
    .req_sh    (sh_req),
    .req_exp   (exp_req),
    .rr_last   (rr_last_reg),
    .gnt       (gnt),
    .win_src   (win_src),
    .win_valid (win_valid)
  );

  assign hold_timeout = STATS_EN && (RESULT_TO > 0) &&
                        (hold_cnt_reg == 16'(RESULT_TO - 1));

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rr_last_next   = rr_last_reg;
    mode_next      = mode_reg;
    id_next        = id_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    src_next       = src_reg;
    acc_next       = acc_reg;
    sweep_cnt_next = sweep_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        mode_next = MODE_COLLIDE;
        if (win_valid) begin
          state_next = ST_SWEEP;
          cnt_next   = '0;
          acc_next   = '0;
          src_next   = win_src;
          case (win_src)
            SRC_PLY: begin
              x_next       = ply_x;
              y_next       = ply_y;
              id_next      = ID_PLAYER;
              rr_last_next = 1'b1;
            end
            SRC_SH: begin
              x_next       = sh_x;
              y_next       = sh_y;
              id_next      = ID_SHELL;
              rr_last_next = 1'b0;
            end
            default: begin
              x_next    = sh_x;
              y_next    = sh_y;
              id_next   = ID_SHELL;
              mode_next = MODE_EXPLODE;
            end
          endcase
        end
      end

      ST_SWEEP: begin
        // Flags trail the checker inputs by FLAG_LAT clocks
        if (src_reg != SRC_EXP && cnt_reg >= ACC_FIRST) begin
          acc_next = acc_reg | eng_flags;
        end
        if (cnt_reg == SWEEP_LAST) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
          mode_next  = MODE_COLLIDE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (src_reg != SRC_EXP) begin
          acc_next = acc_reg | eng_flags;
        end
        if (cnt_reg == DRAIN_LAST) begin
          state_next    = ST_HOLD;
          cnt_next      = '0;
          hold_cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          state_next = ST_IDLE;
          if (STATS_EN) begin
            sweep_cnt_next = sweep_cnt_reg + 16'd1;
          end
        end else if (hold_timeout) begin
          state_next = ST_IDLE;
        end else if (STATS_EN) begin
          hold_cnt_next = hold_cnt_reg + 16'd1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_1M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rr_last_reg   <= 1'b0;
      mode_reg      <= MODE_COLLIDE;
      id_reg        <= ID_SHELL;
      x_reg         <= '0;
      y_reg         <= '0;
      src_reg       <= SRC_PLY;
      acc_reg       <= '0;
      sweep_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rr_last_reg   <= rr_last_next;
      mode_reg      <= mode_next;
      id_reg        <= id_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      src_reg       <= src_next;
      acc_reg       <= acc_next;
      sweep_cnt_reg <= sweep_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  assign ply_gnt   = gnt[SRC_PLY];
  assign sh_gnt    = gnt[SRC_SH];
  assign exp_gnt   = gnt[SRC_EXP];
  assign eng_mode  = mode_reg;
  assign eng_id    = id_reg;
  assign eng_x     = x_reg;
  assign eng_y     = y_reg;
  assign res_valid = (state_reg == ST_HOLD);
  assign res_src   = src_reg;
  assign res_flags = acc_reg;
  assign sweep_cnt = sweep_cnt_reg;

endmodule
